// File: rtl/rv32im_decode_stage.sv
// rv32im_decode_stage: RV32IM decoder with one registered output entry,
// valid/ready handshake, flush, and M-unit busy tracking for hazards.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/instr upstream;
// flush drops the output entry; out_valid/out_ready plus the decoded
// bundle downstream; md_busy reports an M op still in flight.
module rv32im_decode_stage #(
  parameter int M_EXT      = 1,
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        rs1_valid,
  output logic        rs2_valid,
  output logic        rd_valid,
  output logic [3:0]  alu_op,
  output logic [2:0]  imm_fmt,
  output logic [2:0]  br_type,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_size,
  output logic        gprs_we,
  output logic        mem_to_reg,
  output logic        sel_rs1_pc,
  output logic        sel_rs2_imm,
  output logic        jal,
  output logic        jalr,
  output logic        lui,
  output logic        auipc,
  output logic        branch,
  output logic        mul_en,
  output logic        div_en,
  output logic        result_sel,
  output logic [1:0]  sn,
  output logic [1:0]  m_sel,
  output logic        ecall,
  output logic        ebreak,
  output logic        illegal,
  output logic        md_busy
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [5:0] DIV_C = 6'(DIV_CYCLES);
  localparam logic [5:0] MUL_C = 6'(MUL_CYCLES);

  typedef struct packed {
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic       rs1_valid;
    logic       rs2_valid;
    logic       rd_valid;
    logic [3:0] alu_op;
    logic [2:0] imm_fmt;
    logic [2:0] br_type;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       gprs_we;
    logic       mem_to_reg;
    logic       sel_rs1_pc;
    logic       sel_rs2_imm;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic       branch;
    logic       mul_en;
    logic       div_en;
    logic       result_sel;
    logic [1:0] sn;
    logic [1:0] m_sel;
    logic       ecall;
    logic       ebreak;
    logic       illegal;
  } bundle_t;

  bundle_t    dec;
  bundle_t    bundle_q, bundle_d;
  logic       out_valid_q, out_valid_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] pend_rd_q, pend_rd_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       rdw;
  logic       is_op, is_opimm, is_load, is_store, is_branch;
  logic       is_jal, is_jalr, is_lui, is_auipc, is_fence, is_sys;

  logic       in_acc, out_fire;
  logic       haz_out, haz, rd_hit, stall;
  logic [4:0] haz_rd;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign is_op     = opc == OPC_OP;
  assign is_opimm  = opc == OPC_OPIMM;
  assign is_load   = opc == OPC_LOAD;
  assign is_store  = opc == OPC_STORE;
  assign is_branch = opc == OPC_BRANCH;
  assign is_jal    = opc == OPC_JAL;
  assign is_jalr   = opc == OPC_JALR;
  assign is_lui    = opc == OPC_LUI;
  assign is_auipc  = opc == OPC_AUIPC;
  assign is_fence  = opc == OPC_FENCE;
  assign is_sys    = opc == OPC_SYSTEM;

  always_comb begin
    dec = '0;
    rdw = 1'b0;
    dec.rs1_addr = instr[19:15];
    dec.rs2_addr = instr[24:20];
    dec.rd_addr  = instr[11:7];
    unique case (1'b1)
      is_op: begin
        dec.rs1_valid = 1'b1;
        dec.rs2_valid = 1'b1;
        rdw = 1'b1;
        dec.imm_fmt = FMT_R;
        dec.alu_op = {f7[5] & (f3 == 3'b000 || f3 == 3'b101), f3};
        if (f7 == 7'b0000001 && M_EXT != 0) begin
          dec.mul_en = ~f3[2];
          dec.div_en = f3[2];
          dec.result_sel = 1'b1;
          dec.m_sel = f3[1:0];
          case (f3)
            3'b010:                dec.sn = 2'b10;
            3'b011, 3'b101, 3'b111: dec.sn = 2'b00;
            default:               dec.sn = 2'b11;
          endcase
        end else if (!(f7 == 7'b0000000 ||
                       (f7 == 7'b0100000 &&
                        (f3 == 3'b000 || f3 == 3'b101)))) begin
          dec.illegal = 1'b1;
        end
      end
      is_opimm: begin
        dec.rs1_valid = 1'b1;
        rdw = 1'b1;
        dec.imm_fmt = FMT_I;
        dec.sel_rs2_imm = 1'b1;
        dec.alu_op = {(f3 == 3'b101) & instr[30], f3};
        if (f3 == 3'b001 && f7 != 7'b0000000)
          dec.illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
          dec.illegal = 1'b1;
      end
      is_load: begin
        dec.rs1_valid = 1'b1;
        rdw = 1'b1;
        dec.imm_fmt = FMT_I;
        dec.sel_rs2_imm = 1'b1;
        dec.mem_read = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_size = f3;
      end
      is_store: begin
        dec.rs1_valid = 1'b1;
        dec.rs2_valid = 1'b1;
        dec.imm_fmt = FMT_S;
        dec.sel_rs2_imm = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_size = f3;
      end
      is_branch: begin
        dec.rs1_valid = 1'b1;
        dec.rs2_valid = 1'b1;
        dec.imm_fmt = FMT_B;
        dec.branch = 1'b1;
        dec.br_type = f3;
        dec.alu_op = 4'b1000;
      end
      is_jal: begin
        rdw = 1'b1;
        dec.imm_fmt = FMT_J;
        dec.jal = 1'b1;
        dec.sel_rs1_pc = 1'b1;
        dec.sel_rs2_imm = 1'b1;
      end
      is_jalr: begin
        dec.rs1_valid = 1'b1;
        rdw = 1'b1;
        dec.imm_fmt = FMT_I;
        dec.jalr = 1'b1;
        dec.sel_rs2_imm = 1'b1;
      end
      is_lui: begin
        rdw = 1'b1;
        dec.imm_fmt = FMT_U;
        dec.lui = 1'b1;
        dec.sel_rs2_imm = 1'b1;
      end
      is_auipc: begin
        rdw = 1'b1;
        dec.imm_fmt = FMT_U;
        dec.auipc = 1'b1;
        dec.sel_rs1_pc = 1'b1;
        dec.sel_rs2_imm = 1'b1;
      end
      is_fence: begin
        dec.imm_fmt = FMT_I;
      end
      is_sys: begin
        dec.imm_fmt = FMT_I;
        if (instr == 32'h0000_0073)
          dec.ecall = 1'b1;
        else if (instr == 32'h0010_0073)
          dec.ebreak = 1'b1;
        else
          dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // x0 is never a real destination, so it never writes or hazards
    dec.rd_valid = rdw && (dec.rd_addr != 5'd0) && !dec.illegal;
    dec.gprs_we  = dec.rd_valid;
    if (dec.illegal) begin
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.mul_en     = 1'b0;
      dec.div_en     = 1'b0;
      dec.result_sel = 1'b0;
      dec.sn         = 2'b00;
      dec.m_sel      = 2'b00;
      dec.jal        = 1'b0;
      dec.jalr       = 1'b0;
      dec.branch     = 1'b0;
    end
  end

  // An M op still in the output register has not started its window,
  // so its rd is the hazard; otherwise the in-flight op's rd is.
  always_comb begin
    haz_out = out_valid_q && (bundle_q.mul_en || bundle_q.div_en);
    haz     = haz_out || (cnt_q != 6'd0);
    haz_rd  = haz_out ? bundle_q.rd_addr : pend_rd_q;
    rd_hit  = (haz_rd != 5'd0) &&
              ((dec.rs1_valid && dec.rs1_addr == haz_rd) ||
               (dec.rs2_valid && dec.rs2_addr == haz_rd) ||
               (dec.rd_valid  && dec.rd_addr  == haz_rd));
    stall   = haz && (dec.mul_en || dec.div_en || rd_hit);
  end

  assign in_ready = !rst && !flush && !stall && (!out_valid_q || out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    pend_rd_d   = pend_rd_q;
    if (in_acc)
      bundle_d = dec;
    if (flush)
      out_valid_d = 1'b0;
    else if (in_acc)
      out_valid_d = 1'b1;
    else if (out_fire)
      out_valid_d = 1'b0;
    if (cnt_q != 6'd0)
      cnt_d = cnt_q - 6'd1;
    if (out_fire && bundle_q.div_en) begin
      cnt_d     = DIV_C;
      pend_rd_d = bundle_q.rd_addr;
    end else if (out_fire && bundle_q.mul_en && MUL_C != 6'd0) begin
      cnt_d     = MUL_C;
      pend_rd_d = bundle_q.rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= 6'd0;
      pend_rd_q   <= 5'd0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign md_busy     = cnt_q != 6'd0;
  assign rs1_addr    = bundle_q.rs1_addr;
  assign rs2_addr    = bundle_q.rs2_addr;
  assign rd_addr     = bundle_q.rd_addr;
  assign rs1_valid   = bundle_q.rs1_valid;
  assign rs2_valid   = bundle_q.rs2_valid;
  assign rd_valid    = bundle_q.rd_valid;
  assign alu_op      = bundle_q.alu_op;
  assign imm_fmt     = bundle_q.imm_fmt;
  assign br_type     = bundle_q.br_type;
  assign mem_read    = bundle_q.mem_read;
  assign mem_write   = bundle_q.mem_write;
  assign mem_size    = bundle_q.mem_size;
  assign gprs_we     = bundle_q.gprs_we;
  assign mem_to_reg  = bundle_q.mem_to_reg;
  assign sel_rs1_pc  = bundle_q.sel_rs1_pc;
  assign sel_rs2_imm = bundle_q.sel_rs2_imm;
  assign jal         = bundle_q.jal;
  assign jalr        = bundle_q.jalr;
  assign lui         = bundle_q.lui;
  assign auipc       = bundle_q.auipc;
  assign branch      = bundle_q.branch;
  assign mul_en      = bundle_q.mul_en;
  assign div_en      = bundle_q.div_en;
  assign result_sel  = bundle_q.result_sel;
  assign sn          = bundle_q.sn;
  assign m_sel       = bundle_q.m_sel;
  assign ecall       = bundle_q.ecall;
  assign ebreak      = bundle_q.ebreak;
  assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_rv32im_decode_stage.sv
// tb_rv32im_decode_stage: directed bench for the RV32IM decode stage,
// with a second instance built with M_EXT=0.
module tb_rv32im_decode_stage;

  logic        clk, rst, in_valid, flush, out_ready;
  logic [31:0] instr;

  logic        in_ready, out_valid;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_valid, rs2_valid, rd_valid;
  logic [3:0]  alu_op;
  logic [2:0]  imm_fmt, br_type, mem_size;
  logic        mem_read, mem_write, gprs_we, mem_to_reg;
  logic        sel_rs1_pc, sel_rs2_imm, jal, jalr, lui, auipc, branch;
  logic        mul_en, div_en, result_sel, ecall, ebreak, illegal, md_busy;
  logic [1:0]  sn, m_sel;

  logic        n_in_ready, n_out_valid;
  logic [4:0]  n_rs1_addr, n_rs2_addr, n_rd_addr;
  logic        n_rs1_valid, n_rs2_valid, n_rd_valid;
  logic [3:0]  n_alu_op;
  logic [2:0]  n_imm_fmt, n_br_type, n_mem_size;
  logic        n_mem_read, n_mem_write, n_gprs_we, n_mem_to_reg;
  logic        n_sel_rs1_pc, n_sel_rs2_imm, n_jal, n_jalr, n_lui, n_auipc;
  logic        n_branch, n_mul_en, n_div_en, n_result_sel;
  logic        n_ecall, n_ebreak, n_illegal, n_md_busy;
  logic [1:0]  n_sn, n_m_sel;

  int nchk = 0;
  int nfail = 0;

  localparam logic [31:0] I_DIV5   = 32'h027342B3;
  localparam logic [31:0] I_ADD8   = 32'h00128433;
  localparam logic [31:0] I_ADD9   = 32'h002084B3;
  localparam logic [31:0] I_MUL3   = 32'h022081B3;
  localparam logic [31:0] I_MULHSU = 32'h02C5A533;

  localparam int NT = 12;
  localparam logic [31:0] T_INS [NT] = '{
    32'h403100B3, 32'h40335293, 32'h20335293, 32'h00812203,
    32'h00208463, 32'h00000073, 32'h34011073, 32'h0000007F,
    32'h00208033, 32'h00512223, 32'h123453B7, 32'h402090B3};
  localparam logic [3:0] T_ALU [NT] = '{
    4'h8, 4'hD, 4'h5, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
  localparam logic T_ILL [NT] = '{
    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic T_WE [NT] = '{
    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [2:0] T_FMT [NT] = '{
    3'd5, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd5, 3'd1, 3'd4, 3'd5};

  rv32im_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .rd_valid(rd_valid), .alu_op(alu_op), .imm_fmt(imm_fmt),
    .br_type(br_type), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .gprs_we(gprs_we), .mem_to_reg(mem_to_reg),
    .sel_rs1_pc(sel_rs1_pc), .sel_rs2_imm(sel_rs2_imm), .jal(jal),
    .jalr(jalr), .lui(lui), .auipc(auipc), .branch(branch),
    .mul_en(mul_en), .div_en(div_en), .result_sel(result_sel),
    .sn(sn), .m_sel(m_sel), .ecall(ecall), .ebreak(ebreak),
    .illegal(illegal), .md_busy(md_busy));

  rv32im_decode_stage #(.M_EXT(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .instr(instr), .flush(flush), .out_valid(n_out_valid),
    .out_ready(out_ready), .rs1_addr(n_rs1_addr), .rs2_addr(n_rs2_addr),
    .rd_addr(n_rd_addr), .rs1_valid(n_rs1_valid), .rs2_valid(n_rs2_valid),
    .rd_valid(n_rd_valid), .alu_op(n_alu_op), .imm_fmt(n_imm_fmt),
    .br_type(n_br_type), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .mem_size(n_mem_size), .gprs_we(n_gprs_we), .mem_to_reg(n_mem_to_reg),
    .sel_rs1_pc(n_sel_rs1_pc), .sel_rs2_imm(n_sel_rs2_imm), .jal(n_jal),
    .jalr(n_jalr), .lui(n_lui), .auipc(n_auipc), .branch(n_branch),
    .mul_en(n_mul_en), .div_en(n_div_en), .result_sel(n_result_sel),
    .sn(n_sn), .m_sel(n_m_sel), .ecall(n_ecall), .ebreak(n_ebreak),
    .illegal(n_illegal), .md_busy(n_md_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (md_busy && n < 100) begin
      cyc();
      n++;
    end
    nchk++;
    if (md_busy !== 1'b0) begin
      nfail++;
      $display("FAIL wait_idle: md_busy=%b required 0", md_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    instr = 32'h0;
    flush = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    nchk++;
    if (in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    nchk++;
    if ({out_valid, md_busy, rd_addr, alu_op, gprs_we} !== '0) begin
      nfail++;
      $display("FAIL reset_state: ov=%b busy=%b rd=%0d alu=%h we=%b",
               out_valid, md_busy, rd_addr, alu_op, gprs_we);
    end
    rst = 1'b0;
    #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    instr = 32'h00B50533;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL add_in_ready: got %b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    nchk++;
    if (out_valid !== 1'b1 || alu_op !== 4'b0000 || gprs_we !== 1'b1 ||
        rd_addr !== 5'd10 || illegal !== 1'b0) begin
      nfail++;
      $display("FAIL add_decode: ov=%b alu=%b we=%b rd=%0d ill=%b req 1 0000 1 10 0",
               out_valid, alu_op, gprs_we, rd_addr, illegal);
    end
    nchk++;
    if (rs1_addr !== 5'd10 || rs2_addr !== 5'd11 || imm_fmt !== 3'b101) begin
      nfail++;
      $display("FAIL add_fields: rs1=%0d rs2=%0d fmt=%b req 10 11 101",
               rs1_addr, rs2_addr, imm_fmt);
    end
    cyc();
    nchk++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL add_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_decode_table();
    out_ready = 1'b1;
    for (int i = 0; i < NT; i++) begin
      instr = T_INS[i];
      in_valid = 1'b1;
      cyc();
      nchk++;
      if (out_valid !== 1'b1 || alu_op !== T_ALU[i] ||
          illegal !== T_ILL[i] || gprs_we !== T_WE[i] ||
          imm_fmt !== T_FMT[i]) begin
        nfail++;
        $display("FAIL table[%0d] %h: ov=%b alu=%h ill=%b we=%b fmt=%0d req 1 %h %b %b %0d",
                 i, T_INS[i], out_valid, alu_op, illegal, gprs_we, imm_fmt,
                 T_ALU[i], T_ILL[i], T_WE[i], T_FMT[i]);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_div_hazard();
    int n;
    instr = I_DIV5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    nchk++;
    if (out_valid !== 1'b1 || div_en !== 1'b1 || mul_en !== 1'b0 ||
        sn !== 2'b11 || result_sel !== 1'b1 || rd_addr !== 5'd5) begin
      nfail++;
      $display("FAIL div_decode: ov=%b div=%b mul=%b sn=%b rs=%b rd=%0d",
               out_valid, div_en, mul_en, sn, result_sel, rd_addr);
    end
    cyc();
    instr = I_ADD8;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      cyc();
      n++;
    end
    nchk++;
    if (n != 32) begin
      nfail++;
      $display("FAIL div_stall_cycles: got %0d required 32", n);
    end
    cyc();
    in_valid = 1'b0;
    nchk++;
    if (out_valid !== 1'b1 || rd_addr !== 5'd8 || rs1_addr !== 5'd5) begin
      nfail++;
      $display("FAIL div_then_add: ov=%b rd=%0d rs1=%0d req 1 8 5",
               out_valid, rd_addr, rs1_addr);
    end
    cyc();
  endtask

  task automatic test_full_block();
    wait_idle();
    instr = I_DIV5;
    in_valid = 1'b1;
    out_ready = 1'b0;
    cyc();
    instr = I_ADD9;
    #1;
    nchk++;
    if (in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL full_block_ready: got %b required 0", in_ready);
    end
    cyc();
    nchk++;
    if (out_valid !== 1'b1 || div_en !== 1'b1 || rd_addr !== 5'd5) begin
      nfail++;
      $display("FAIL full_block_hold: ov=%b div=%b rd=%0d req 1 1 5",
               out_valid, div_en, rd_addr);
    end
    out_ready = 1'b1;
    #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL full_block_release: in_ready=%b required 1", in_ready);
    end
    cyc();
    nchk++;
    if (out_valid !== 1'b1 || rd_addr !== 5'd9 || md_busy !== 1'b1) begin
      nfail++;
      $display("FAIL full_block_accept: ov=%b rd=%0d busy=%b req 1 9 1",
               out_valid, rd_addr, md_busy);
    end
    instr = I_MUL3;
    #1;
    nchk++;
    if (in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL structural_stall: in_ready=%b required 0", in_ready);
    end
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_mul();
    instr = I_MUL3;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    nchk++;
    if (mul_en !== 1'b1 || div_en !== 1'b0 || sn !== 2'b11 ||
        m_sel !== 2'b00 || rd_addr !== 5'd3) begin
      nfail++;
      $display("FAIL mul_decode: mul=%b div=%b sn=%b msel=%b rd=%0d",
               mul_en, div_en, sn, m_sel, rd_addr);
    end
    cyc();
    nchk++;
    if (md_busy !== 1'b1) begin
      nfail++;
      $display("FAIL mul_busy1: md_busy=%b required 1", md_busy);
    end
    cyc();
    nchk++;
    if (md_busy !== 1'b1) begin
      nfail++;
      $display("FAIL mul_busy2: md_busy=%b required 1", md_busy);
    end
    cyc();
    nchk++;
    if (md_busy !== 1'b0) begin
      nfail++;
      $display("FAIL mul_busy_end: md_busy=%b required 0", md_busy);
    end
  endtask

  task automatic test_mext0();
    instr = I_MULHSU;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    nchk++;
    if (n_out_valid !== 1'b1 || n_illegal !== 1'b1 ||
        n_gprs_we !== 1'b0 || n_mul_en !== 1'b0) begin
      nfail++;
      $display("FAIL mext0_mulhsu: ov=%b ill=%b we=%b mul=%b req 1 1 0 0",
               n_out_valid, n_illegal, n_gprs_we, n_mul_en);
    end
    nchk++;
    if (mul_en !== 1'b1 || illegal !== 1'b0 || sn !== 2'b10 ||
        m_sel !== 2'b10) begin
      nfail++;
      $display("FAIL mext1_mulhsu: mul=%b ill=%b sn=%b msel=%b req 1 0 10 10",
               mul_en, illegal, sn, m_sel);
    end
    cyc();
    wait_idle();
  endtask

  task automatic test_flush();
    instr = I_DIV5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    instr = I_ADD9;
    in_valid = 1'b1;
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    nchk++;
    if (out_valid !== 1'b1 || rd_addr !== 5'd9) begin
      nfail++;
      $display("FAIL flush_setup: ov=%b rd=%0d req 1 9", out_valid, rd_addr);
    end
    flush = 1'b1;
    #1;
    nchk++;
    if (in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    cyc();
    flush = 1'b0;
    nchk++;
    if (out_valid !== 1'b0 || md_busy !== 1'b1 || dut.cnt_q !== 6'd30) begin
      nfail++;
      $display("FAIL flush_clear: ov=%b busy=%b cnt=%0d req 0 1 30",
               out_valid, md_busy, dut.cnt_q);
    end
    cyc();
    nchk++;
    if (md_busy !== 1'b1 || dut.cnt_q !== 6'd29) begin
      nfail++;
      $display("FAIL flush_keep_count: busy=%b cnt=%0d req 1 29",
               md_busy, dut.cnt_q);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_div();
    instr = I_DIV5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    instr = I_ADD9;
    in_valid = 1'b1;
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    nchk++;
    if (dut.cnt_q !== 6'd17 || out_valid !== 1'b1 || md_busy !== 1'b1) begin
      nfail++;
      $display("FAIL mid_div_setup: cnt=%0d ov=%b busy=%b req 17 1 1",
               dut.cnt_q, out_valid, md_busy);
    end
    rst = 1'b1;
    cyc();
    nchk++;
    if (dut.cnt_q !== 6'd0 || md_busy !== 1'b0 || out_valid !== 1'b0 ||
        rd_addr !== 5'd0) begin
      nfail++;
      $display("FAIL mid_div_reset: cnt=%0d busy=%b ov=%b rd=%0d req 0 0 0 0",
               dut.cnt_q, md_busy, out_valid, rd_addr);
    end
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode_table();
    test_div_hazard();
    test_full_block();
    test_mul();
    test_mext0();
    test_flush();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/rv32im_decode_stage.md
RV32IM_DECODE_STAGE -- requirements
Module: rv32im_decode_stage

Interface
REQ-001 SHALL have parameter M_EXT, default 1; 1 decodes RV32M, 0 flags OP/funct7=0000001 as illegal.
REQ-002 SHALL have parameter DIV_CYCLES, default 32; the DIV/DIVU/REM/REMU busy window in cycles, range 1..63.
REQ-003 SHALL have parameter MUL_CYCLES, default 2; the MUL* busy window in cycles, range 0..63, where 0 means no mul tracking.
REQ-004 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instr valid
- in_ready  out  1  stage accepts instr
- instr  in  32  raw instruction
- flush  in  1  discard output register
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- rs1_addr, rs2_addr, rd_addr  out  5 each  instr[19:15], [24:20], [11:7]
- rs1_valid, rs2_valid, rd_valid  out  1 each  operand and destination used
- alu_op  out  4  {funct7[5],funct3} for SRL/SRA/SRLI/SRAI/ADD/SUB; {0,funct3} for other OP/OP-IMM; 4'b1000 for branch; 0 otherwise
- imm_fmt  out  3  I=000 S=001 B=010 J=011 U=100 R=101
- br_type  out  3  funct3 when branch, else 0
- mem_read, mem_write, mem_size  out  1,1,3  load/store, mem_size=funct3
- gprs_we, mem_to_reg, sel_rs1_pc, sel_rs2_imm  out  1 each  datapath selects
- jal, jalr, lui, auipc, branch  out  1 each  class flags
- mul_en, div_en, result_sel  out  1 each  M op class, result_sel = M result
- sn, m_sel  out  2 each  operand signedness {rs1,rs2} and result select, RV32M encoding
- ecall, ebreak, illegal  out  1 each  system and exception flags
- md_busy  out  1  M unit window active

Function
REQ-006 SHALL hold one registered output entry; decoded fields SHALL change only on input acceptance (in_valid && in_ready).
REQ-007 SHALL drive in_ready = !rst && !flush && !stall && (!out_valid || out_ready).
REQ-008 SHALL set out_valid to 1 on acceptance, clear it on an output fire with no acceptance, and hold it otherwise.
REQ-009 SHALL keep the bundle stable while out_valid && !out_ready.
REQ-010 SHALL set illegal=1 for any of: an opcode outside the RV32IM set; OP with funct7 not in {0000000, 0100000 with funct3 000/101, 0000001 with M_EXT=1}; shift-immediate with bad funct7; SYSTEM other than ECALL/EBREAK.
REQ-011 SHALL drive gprs_we, mem_read, mem_write, mul_en, div_en, jal, jalr and branch to 0 whenever illegal=1.
REQ-012 SHALL force rd_valid=0 and gprs_we=0 when rd_addr=0.
REQ-013 SHALL define the hazard source as follows.
- If out_valid and the output entry has mul_en or div_en: the hazard rd is the output entry rd_addr.
- Else if md_busy: the hazard rd is pend_rd.
- Else: there is no hazard.
REQ-014 SHALL assert stall when a hazard exists and the incoming instruction matches any of:
- is an M op (structural);
- rs1_valid && rs1==hazard rd;
- rs2_valid && rs2==hazard rd;
- rd_valid && rd==hazard rd.
A hazard rd of 0 matches only the structural case.
REQ-015 SHALL, on an output fire of a div op, load cnt with DIV_CYCLES and pend_rd with rd_addr.
REQ-016 SHALL, on an output fire of a mul op, load cnt with MUL_CYCLES; when MUL_CYCLES=0, cnt is not loaded.
REQ-017 SHALL decrement cnt by 1 per cycle while it is nonzero; a load SHALL take priority over a decrement in the same cycle.
REQ-018 SHALL drive md_busy = (cnt != 0) and keep cnt 6 bits wide.
REQ-019 SHALL, on flush, clear out_valid and refuse input that cycle.
REQ-020 SHALL let cnt and pend_rd continue after a flush, because an already-fired op is in flight.
REQ-021 SHALL add zero latency to in_ready; the decode latency SHALL be exactly 1 cycle from acceptance to out_valid.

Reset
REQ-022 SHALL, with rst high at a clk edge, clear out_valid, cnt, pend_rd and every bundle field to 0; in_ready SHALL be 0 while rst is high.
REQ-023 SHALL let reset override flush, a handshake and a cnt load in the same cycle.

Verification
REQ-024 Bench SHALL cover: instr 0x00B50533 (add x10,x10,x11) accepted, out_ready=1 -> next cycle out_valid=1, alu_op=0000, gprs_we=1, rd_addr=10, illegal=0.
REQ-025 Bench SHALL cover: DIV x5,x6,x7 fires, then ADD x8,x5,x1 offered -> in_ready=0 for exactly DIV_CYCLES cycles (32), then accepted.
REQ-026 Bench SHALL cover: DIV x5 sits in the output register with out_ready=0 and ADD x9,x1,x2 is offered -> in_ready=0, since the full register blocks the pipeline; once out_ready=1, ADD is accepted in that same cycle with no hazard.
REQ-027 Bench SHALL cover: instr 0x02C5A533 (MULHSU) with M_EXT=0 -> illegal=1, gprs_we=0, mul_en=0.
REQ-028 Bench SHALL cover: flush asserted while out_valid=1 -> out_valid=0 next cycle; an md_busy started earlier keeps counting.
REQ-029 Bench SHALL cover: rst asserted mid-divide (cnt=17) -> cnt=0, md_busy=0, out_valid=0 next cycle.
